// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller for the EX stage. It owns the HI/LO
// registers and stalls EX while a multiply or divide is in flight.
// It runs two kinds of operation:
// - a multi-cycle multiply whose product is registered in the start cycle;
// - a 32-iteration restoring divide, one quotient bit per cycle, MSB first.
//
// Parameter:
//   MUL_LAT     multiply stall cycles after the start cycle (1..8)
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   ex_valid    EX holds a valid instruction
//   ex_adv      EX instruction leaves EX at this edge
//   flush       cancel the EX instruction and any operation in flight
//   mult, div   multiply / divide instruction in EX
//   mdsign      1: signed multiply or divide
//   hilowen     {mthi, mtlo} write enables (used when mult=div=0)
//   hiloren     2'b10 reads HI, 2'b01 reads LO
//   rega, regb  GPR[rs], GPR[rt] operands
//   stall       hold EX; the operation has not finished
//   busy        controller is not idle
//   hilo_rdata  selected HI/LO value, 0 when no read is selected
//
// Build option: defining MDU_DIV_ZERO_FAST_EN lets a divide by zero finish
// in the start cycle, with LO=0xFFFFFFFF and HI=rega.
module mdu_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ex_valid,
   input  logic        ex_adv,
   input  logic        flush,
   input  logic        mult,
   input  logic        div,
   input  logic        mdsign,
   input  logic [1:0]  hilowen,
   input  logic [1:0]  hiloren,
   input  logic [31:0] rega,
   input  logic [31:0] regb,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hilo_rdata
);

`ifdef MDU_DIV_ZERO_FAST_EN
   localparam bit DIV_ZERO_FAST = 1'b1;
`else
   localparam bit DIV_ZERO_FAST = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  cnt_reg;
   logic [63:0] prod_reg;
   logic [31:0] hi_reg, lo_reg;
   logic [31:0] quo_reg;      // dividend shifts out of the top, quotient bits enter at the bottom
   logic [31:0] dvs_reg;
   logic [31:0] rem_reg;
   logic        neg_q_reg, neg_r_reg;

   logic        start, mt_wr, div_zero_fast;
   logic [63:0] a_ext, b_ext;
   logic        a_neg, b_neg;
   logic [31:0] a_abs, b_abs;
   logic [32:0] trial, diff;
   logic        q_bit;

   assign start = ex_valid & (mult | div) & ~flush & (state_reg == IDLE);
   assign mt_wr = (state_reg == IDLE) & ex_valid & ex_adv & ~flush & ~mult & ~div;
   assign div_zero_fast = DIV_ZERO_FAST & (regb == 32'd0);

   // Gated by resetn so EX is never held while the controller is in reset.
   assign stall = resetn & ex_valid & (mult | div) & ~flush & (state_reg != DONE);
   assign busy  = (state_reg != IDLE);

   always_comb begin
      hilo_rdata = 32'd0;
      case (hiloren)
         2'b10:   hilo_rdata = hi_reg;
         2'b01:   hilo_rdata = lo_reg;
         default: hilo_rdata = 32'd0;
      endcase
   end

   // Extending the operands to 64 bits makes the low 64 bits of a single
   // product correct for both signed and unsigned multiplies.
   assign a_ext = mdsign ? {{32{rega[31]}}, rega} : {32'd0, rega};
   assign b_ext = mdsign ? {{32{regb[31]}}, regb} : {32'd0, regb};

   assign a_neg = mdsign & rega[31];
   assign b_neg = mdsign & regb[31];
   assign a_abs = a_neg ? (~rega + 32'd1) : rega;
   assign b_abs = b_neg ? (~regb + 32'd1) : regb;

   // Restoring step: the partial remainder stays below the divisor, so the
   // trial value fits in 33 bits and bit 32 of the difference is the borrow.
   // A zero divisor never borrows, which yields an all-ones quotient and a
   // remainder equal to the dividend.
   assign trial = {rem_reg, quo_reg[31]};
   assign diff  = trial - {1'b0, dvs_reg};
   assign q_bit = ~diff[32];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (mult)               state_next = MUL;
               else if (div_zero_fast) state_next = DONE;
               else                    state_next = DIV;
            end
         end
         MUL:  if (cnt_reg == 5'd0) state_next = DONE;
         DIV:  if (cnt_reg == 5'd0) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: if (ex_adv || !ex_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_reg   <= 5'd0;
         prod_reg  <= 64'd0;
         hi_reg    <= 32'd0;
         lo_reg    <= 32'd0;
         quo_reg   <= 32'd0;
         dvs_reg   <= 32'd0;
         rem_reg   <= 32'd0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (mult) begin
                     prod_reg <= a_ext * b_ext;
                     cnt_reg  <= 5'(MUL_LAT - 1);
                  end else if (div_zero_fast) begin
                     lo_reg <= 32'hFFFF_FFFF;
                     hi_reg <= rega;
                  end else begin
                     quo_reg   <= a_abs;
                     dvs_reg   <= b_abs;
                     rem_reg   <= 32'd0;
                     neg_q_reg <= a_neg ^ b_neg;
                     neg_r_reg <= a_neg;
                     cnt_reg   <= 5'd31;
                  end
               end else if (mt_wr) begin
                  if (hilowen[1]) hi_reg <= rega;
                  if (hilowen[0]) lo_reg <= rega;
               end
            end
            MUL: begin
               if (cnt_reg == 5'd0) begin
                  if (!flush) begin
                     hi_reg <= prod_reg[63:32];
                     lo_reg <= prod_reg[31:0];
                  end
               end else begin
                  cnt_reg <= cnt_reg - 5'd1;
               end
            end
            DIV: begin
               rem_reg <= q_bit ? diff[31:0] : trial[31:0];
               quo_reg <= {quo_reg[30:0], q_bit};
               if (cnt_reg != 5'd0) cnt_reg <= cnt_reg - 5'd1;
            end
            FIX: begin
               if (!flush) begin
                  lo_reg <= neg_q_reg ? (~quo_reg + 32'd1) : quo_reg;
                  hi_reg <= neg_r_reg ? (~rem_reg + 32'd1) : rem_reg;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver pushes expected stall lengths and
// HI/LO read values, and a monitor pops and compares them as the DUT
// presents completions and reads.
module tb_mdu_ctrl;
   localparam int MUL_LAT = 2;
`ifdef MDU_DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk, resetn, ex_valid, ex_adv, flush, mult, div, mdsign;
   logic [1:0]  hilowen, hiloren;
   logic [31:0] rega, regb;
   logic        stall, busy;
   logic [31:0] hilo_rdata;

   mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_adv(ex_adv),
      .flush(flush), .mult(mult), .div(div), .mdsign(mdsign),
      .hilowen(hilowen), .hiloren(hiloren), .rega(rega), .regb(regb),
      .stall(stall), .busy(busy), .hilo_rdata(hilo_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind 0: stall cycles of a completed op, 1: hilo_rdata, 2: busy probe
   typedef struct {
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] m_hi, m_lo;
   logic        probe;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("[TB] %s ok %h", name, act);
      end
   endfunction

   function automatic void push(int kind, logic [31:0] val);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endfunction

   // Reference model: plain integer arithmetic on the architectural rules.
   function automatic void model(input bit isdiv, input bit sgn,
                                 input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb_, q, r;
      logic [63:0] p;
      if (!isdiv) begin
         if (sgn) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
            p = 64'(sa * sb_);
         end else begin
            p = {32'd0, a} * {32'd0, b};
         end
         m_hi = p[63:32];
         m_lo = p[31:0];
      end else if (b == 32'd0) begin
         m_lo = 32'hFFFF_FFFF;
         m_hi = a;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb_ = longint'($signed(b));
         q = sa / sb_;
         r = sa % sb_;
         m_lo = q[31:0];
         m_hi = r[31:0];
      end else begin
         m_lo = a / b;
         m_hi = a % b;
      end
   endfunction

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      int   cnt;
      exp_t e;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            cnt = 0;
         end else if (ex_valid && flush) begin
            chk("flush_stall", {31'd0, stall}, 32'd0);
            cnt = 0;
         end else if (probe || (ex_valid && (mult || div) && !stall && ex_adv) ||
                      (ex_valid && !mult && !div && hiloren != 2'b00)) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               case (e.kind)
                  0: begin chk("stall_cycles", 32'(cnt), e.val); cnt = 0; end
                  1: chk("hilo_rdata", hilo_rdata, e.val);
                  default: chk("busy", {31'd0, busy}, e.val);
               endcase
            end
         end else if (ex_valid && (mult || div) && stall) begin
            cnt++;
         end
      end
   end

   task automatic idle_inputs();
      ex_valid = 0; ex_adv = 0; flush = 0; mult = 0; div = 0; mdsign = 0;
      hilowen = 2'b00; hiloren = 2'b00; rega = 0; regb = 0; probe = 0;
   endtask

   task automatic do_op(input bit isdiv, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
      int n;
      push(0, isdiv ? ((FAST && b == 32'd0) ? 32'd1 : 32'd34) : 32'(1 + MUL_LAT));
      model(isdiv, sgn, a, b);
      ex_valid = 1; mult = !isdiv; div = isdiv; mdsign = sgn;
      rega = a; regb = b; ex_adv = 0;
      #1;
      n = 0;
      while (stall && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("op_timeout", 32'd1, 32'd0);
      repeat (hold) begin @(posedge clk); #1; end
      ex_adv = 1;
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic do_read(input logic [1:0] sel);
      push(1, (sel == 2'b10) ? m_hi : m_lo);
      ex_valid = 1; hiloren = sel; ex_adv = 1;
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic read_both();
      do_read(2'b10);
      do_read(2'b01);
   endtask

   task automatic do_mt(input logic [1:0] wen, input logic [31:0] val);
      ex_valid = 1; ex_adv = 1; hilowen = wen; rega = val;
      if (wen[1]) m_hi = val;
      if (wen[0]) m_lo = val;
      @(posedge clk); #1;
      idle_inputs();
   endtask

   // Starts an op, lets 'edges' clock edges pass, then flushes for one cycle.
   task automatic flush_op(input bit isdiv, input logic [31:0] a,
                           input logic [31:0] b, input int edges);
      ex_valid = 1; mult = !isdiv; div = isdiv; mdsign = 0; rega = a; regb = b;
      repeat (edges) @(posedge clk);
      #1 flush = 1;
      @(posedge clk); #1;
      idle_inputs();
      push(2, 32'd0);
      probe = 1;
      @(posedge clk); #1;
      probe = 0;
   endtask

   initial begin
      logic [31:0] a, b;
      bit          isdiv, sgn;
      idle_inputs();
      resetn = 0;
      m_hi = 0; m_lo = 0;
      #2;
      ex_valid = 1; mult = 1; hiloren = 2'b10;
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hilo_rdata, 32'd0);
      hiloren = 2'b01;
      #1;
      chk("rst_lo", hilo_rdata, 32'd0);
      idle_inputs();
      @(posedge clk); #1;
      resetn = 1;
      @(posedge clk); #1;

      do_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); read_both();
      do_op(0, 1, 32'hFFFF_FFFD, 32'd7, 0);         do_read(2'b10); do_read(2'b01);
      do_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0);         read_both();
      do_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0); read_both();
      do_op(1, 0, 32'd100, 32'd0, 0);               read_both();

      // Flush in DIV cycle 10: start edge plus nine more DIV edges.
      flush_op(1, 32'd10, 32'd3, 10);
      read_both();
      do_mt(2'b01, 32'h0000_1234);
      do_read(2'b01);

      // Flush in the final MUL cycle and in FIX suppresses the write.
      flush_op(0, 32'd5, 32'd6, MUL_LAT);
      read_both();
      flush_op(1, 32'd7, 32'd7, 33);
      read_both();

      // DONE held by other stalls: no restart, single result.
      do_op(1, 0, 32'd9, 32'd4, 5); read_both();

      // Reset in the middle of a multiply clears HI/LO and returns to idle.
      ex_valid = 1; mult = 1; rega = 32'd11; regb = 32'd13;
      @(posedge clk); @(posedge clk); #1;
      resetn = 0;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_stall", {31'd0, stall}, 32'd0);
      m_hi = 0; m_lo = 0;
      idle_inputs();
      @(posedge clk); #1;
      resetn = 1;
      read_both();

      do_mt(2'b10, 32'hCAFE_F00D);
      do_read(2'b10);

      for (int i = 0; i < 40; i++) begin
         isdiv = 1'($urandom_range(0, 1));
         sgn   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0: a = 32'd0;
            1: a = 32'h8000_0000;
            2: a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'd1;
            3: b = $urandom_range(2, 100);
            default: b = $urandom;
         endcase
         if (isdiv && sgn && b == 32'd0 && !FAST) b = 32'd1;
         do_op(isdiv, sgn, a, b, $urandom_range(0, 2));
         if ($urandom_range(0, 3) != 0) read_both();
      end
      read_both();

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
